// File: rtl/slow_mem_responder_if.sv
// -----------------------------------------------------------------------------
// slow_mem_responder_if
// Line-transfer bus between a cache (master) and the slow memory responder
// (slave). One 128-bit line per request, completed by a one-cycle mem_ready.
//
// Signals:
//   mem_read   cache -> mem  line read request
//   mem_write  cache -> mem  line write request
//   mem_addr   cache -> mem  line address, byte address bits [31:4]
//   mem_wdata  cache -> mem  write line data
//   mem_rdata  mem -> cache  read line data
//   mem_ready  mem -> cache  completion strobe, one cycle per request
// -----------------------------------------------------------------------------
interface slow_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/slow_mem_responder.sv
// -----------------------------------------------------------------------------
// slow_mem_responder
// Synthesizable fixed-latency line store answering the cache line protocol.
// One request is accepted at a time; after LATENCY cycles it completes with a
// single-cycle mem_ready, followed by one dead (GAP) cycle so Moore-style
// cache FSMs have time to drop their request.
//
// Parameters:
//   LATENCY    cycles from request acceptance to the mem_ready cycle (1..255)
//   ADDR_BITS  line-index bits; the store holds 2^ADDR_BITS 128-bit lines
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (control and mem_rdata only; the
//          line store keeps its contents across reset)
//   mem    slave side of slow_mem_responder_if
// -----------------------------------------------------------------------------
module slow_mem_responder #(
    parameter int LATENCY   = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slow_mem_responder_if.slave  mem
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
    localparam int         LINES    = 1 << ADDR_BITS;

    state_t                state, state_n;
    logic [7:0]            cnt, cnt_n;
    logic                  accept;

    // Request latched at acceptance; governs completion regardless of what
    // the requester does afterwards.
    logic                  op_write;
    logic [ADDR_BITS-1:0]  idx;
    logic [127:0]          wdata_q;

    logic [127:0]          array [LINES];

    logic                  ready_q;
    logic [127:0]          rdata_q;

    logic                  req;
    logic [ADDR_BITS-1:0]  req_idx;
    logic                  rd_fire;
    logic [ADDR_BITS-1:0]  rd_idx;
    logic                  addr_unused;

    assign req         = mem.mem_read | mem.mem_write;
    assign req_idx     = mem.mem_addr[ADDR_BITS-1:0];
    // Upper line-address bits alias onto the same lines.
    assign addr_unused = ^mem.mem_addr[27:ADDR_BITS];

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_n   = CNT_LOAD;
                    state_n = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_n = cnt - 8'd1;
                if (cnt_n == 8'd0) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The read data register is loaded on the edge entering RESP. With
    // LATENCY=1 that edge is also the accepting edge, so the request is
    // taken straight from the bus instead of from the latched copy.
    // A simultaneous read+write is a write, so it never loads read data.
    always_comb begin
        rd_idx  = idx;
        rd_fire = 1'b0;
        if (state == IDLE) begin
            rd_idx  = req_idx;
            rd_fire = (state_n == RESP) && mem.mem_read && !mem.mem_write;
        end else begin
            rd_fire = (state_n == RESP) && !op_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= (state_n == RESP);
            if (rd_fire) begin
                rdata_q <= array[rd_idx];
            end
        end
    end

    // Write data commits on the edge leaving RESP, so a reset before then
    // drops the write.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= mem.mem_write;
            idx      <= req_idx;
            wdata_q  <= mem.mem_wdata;
        end
        if (state == RESP && op_write) begin
            array[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_slow_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_slow_mem_responder
// Directed bench for slow_mem_responder. dut_a runs with LATENCY=8 and carries
// most of the scenarios; dut_b runs with LATENCY=1 for the minimum-latency
// case. Both share clock and reset.
// -----------------------------------------------------------------------------
module tb_slow_mem_responder;
    localparam int LAT_A    = 8;
    localparam int MAX_WAIT = 300;

    localparam logic [127:0] V_FIRST = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] V_LINEB = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
    localparam logic [127:0] V_LINEA = 128'h1111222233334444555566667777_8888;
    localparam logic [127:0] V_IDX5  = 128'hDEADBEEF00000005CAFEF00D55555555;
    localparam logic [127:0] V_ALIAS = 128'h0303030303030303F0F0F0F0F0F0F0F0;
    localparam logic [127:0] V_OLD7  = 128'h7777777700000000777777770000_0000;
    localparam logic [127:0] V_NEW7  = 128'hBADBADBADBADBADBADBADBADBADBAD07;
    localparam logic [127:0] V_B9    = 128'h99999999123456789999999987654321;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic         a_rd = 1'b0, a_wr = 1'b0;
    logic [27:0]  a_addr = '0;
    logic [127:0] a_wd = '0;
    logic         b_rd = 1'b0, b_wr = 1'b0;
    logic [27:0]  b_addr = '0;
    logic [127:0] b_wd = '0;

    slow_mem_responder_if a_if ();
    slow_mem_responder_if b_if ();

    assign a_if.mem_read  = a_rd;
    assign a_if.mem_write = a_wr;
    assign a_if.mem_addr  = a_addr;
    assign a_if.mem_wdata = a_wd;
    assign b_if.mem_read  = b_rd;
    assign b_if.mem_write = b_wr;
    assign b_if.mem_addr  = b_addr;
    assign b_if.mem_wdata = b_wd;

    slow_mem_responder #(.LATENCY(LAT_A), .ADDR_BITS(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (a_if.slave)
    );

    slow_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (b_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on dut_a. The request stays on the bus for 'hold'
    // rising edges (or until mem_ready is seen). Returns the number of rising
    // edges from driving the request to the first mem_ready, the cycle stamp
    // of that mem_ready, and mem_rdata sampled in that cycle.
    task automatic mem_txn(input logic rd, input logic wr, input logic [27:0] addr,
                           input logic [127:0] wd, input int hold,
                           output int lat, output int t_rdy, output logic [127:0] data);
        logic got;
        got   = 1'b0;
        lat   = 0;
        t_rdy = 0;
        data  = '0;
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd;
        for (int c = 1; c <= MAX_WAIT && !got; c++) begin
            @(posedge clk);
            #1;
            if (c == hold) begin
                a_rd = 1'b0; a_wr = 1'b0;
            end
            @(negedge clk);
            if (a_if.mem_ready) begin
                got   = 1'b1;
                lat   = c;
                t_rdy = cyc;
                data  = a_if.mem_rdata;
            end
        end
        a_rd = 1'b0; a_wr = 1'b0;
        check("txn_done", got, 1'b1);
    endtask

    task automatic count_ready(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (a_if.mem_ready) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int lat, t1, t2, cnt;
        logic [127:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready_a", a_if.mem_ready, 1'b0);
        check("rst_rdata_a", a_if.mem_rdata, '0);
        check("rst_ready_b", b_if.mem_ready, 1'b0);
        check("rst_rdata_b", b_if.mem_rdata, '0);
        rst_n = 1'b1;

        // Write held one extra edge: exactly one pulse, LATENCY after request
        mem_txn(1'b0, 1'b1, 28'h0000010, V_FIRST, 2, lat, t1, d);
        check("wr_lat", lat, LAT_A);
        count_ready(12, cnt);
        check("wr_single_pulse", cnt, 0);

        // Read back; rdata holds after ready drops
        mem_txn(1'b1, 1'b0, 28'h0000010, '0, 1, lat, t1, d);
        check("rd_lat", lat, LAT_A);
        check("rd_data", d, V_FIRST);
        count_ready(4, cnt);
        check("rd_single_pulse", cnt, 0);
        check("rd_hold", a_if.mem_rdata, V_FIRST);

        // Dirty miss: write A then immediately read B
        mem_txn(1'b0, 1'b1, 28'h0000020, V_LINEB, 1, lat, t1, d);
        count_ready(3, cnt);
        mem_txn(1'b0, 1'b1, 28'h0000030, V_LINEA, 1, lat, t1, d);
        check("dm_wr_lat", lat, LAT_A);
        mem_txn(1'b1, 1'b0, 28'h0000020, '0, 1000, lat, t2, d);
        check("dm_spacing", t2 - t1, LAT_A + 2);
        check("dm_b_data", d, V_LINEB);
        count_ready(3, cnt);
        check("dm_pulse", cnt, 0);
        mem_txn(1'b1, 1'b0, 28'h0000030, '0, 1, lat, t1, d);
        check("dm_a_commit", d, V_LINEA);
        count_ready(3, cnt);

        // Read and write together: a write; rdata untouched in its RESP
        mem_txn(1'b1, 1'b1, 28'h0000005, V_IDX5, 1, lat, t1, d);
        check("both_lat", lat, LAT_A);
        check("both_rdata_kept", d, V_LINEA);
        count_ready(3, cnt);
        mem_txn(1'b1, 1'b0, 28'h0000005, '0, 1, lat, t1, d);
        check("both_readback", d, V_IDX5);
        count_ready(3, cnt);

        // Aliasing of upper line-address bits
        mem_txn(1'b0, 1'b1, 28'h0000003, V_ALIAS, 1, lat, t1, d);
        count_ready(3, cnt);
        mem_txn(1'b1, 1'b0, 28'h0000103, '0, 1, lat, t1, d);
        check("alias_data", d, V_ALIAS);
        count_ready(3, cnt);

        // Reset in BUSY of a write: no ready, write lost, back to IDLE
        mem_txn(1'b0, 1'b1, 28'h0000007, V_OLD7, 1, lat, t1, d);
        count_ready(3, cnt);
        @(negedge clk);
        a_wr = 1'b1; a_addr = 28'h0000007; a_wd = V_NEW7;
        @(posedge clk);
        #1;
        a_wr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", a_if.mem_ready, 1'b0);
        check("midrst_rdata", a_if.mem_rdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_ready(12, cnt);
        check("midrst_no_ready", cnt, 0);
        mem_txn(1'b1, 1'b0, 28'h0000007, '0, 1, lat, t1, d);
        check("midrst_idle_lat", lat, LAT_A);
        check("midrst_old_data", d, V_OLD7);
        count_ready(3, cnt);

        // LATENCY=1: ready in the cycle right after the request
        @(negedge clk);
        b_wr = 1'b1; b_addr = 28'h0000009; b_wd = V_B9;
        @(posedge clk);
        #1;
        b_wr = 1'b0;
        @(negedge clk);
        check("b_wr_ready", b_if.mem_ready, 1'b1);
        @(negedge clk);
        check("b_wr_pulse", b_if.mem_ready, 1'b0);
        repeat (2) @(negedge clk);
        b_rd = 1'b1;
        @(posedge clk);
        #1;
        b_rd = 1'b0;
        @(negedge clk);
        check("b_rd_ready", b_if.mem_ready, 1'b1);
        check("b_rd_data", b_if.mem_rdata, V_B9);
        @(negedge clk);
        check("b_rd_pulse", b_if.mem_ready, 1'b0);
        check("b_rd_hold", b_if.mem_rdata, V_B9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
